// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester 5-bit mux arbiter.
//   MUX_WIDTH   : data width of the shared MUX2T1_5 (fixed at 5)
//   arb_state_e : output-register occupancy state
//   req_idx_t   : requester index (0 or 1)
package mux_arb_pkg;

  localparam int unsigned MUX_WIDTH = 5;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

  typedef logic req_idx_t;

endpackage

// File: rtl/MUX2T1_5.sv
// Existing 5-bit 2:1 multiplexer shared by the arbiter.
//   I0, I1 : data inputs
//   s      : select, 0 -> I0, 1 -> I1
//   o      : selected word
module MUX2T1_5 (
  input  logic [4:0] I0,
  input  logic [4:0] I1,
  input  logic       s,
  output logic [4:0] o
);

  assign o = s ? I1 : I0;

endmodule

// File: rtl/mux2t1_5_arbiter.sv
// Round-robin arbiter sharing one MUX2T1_5 between two requesters, with a
// one-entry registered output toward a single sink.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req0/data0/gnt0      : requester 0 valid/grant handshake
//   req1/data1/gnt1      : requester 1 valid/grant handshake
//   s                    : mux select (current winner)
//   o_valid/o_data/o_ready : registered output, valid/ready handshake
//   last                 : index of the most recently granted requester
// Build option: define ARB_LOCK_EN to add burst lock (owner keeps ties for
// up to MAX_BURST consecutive grants). Undefined: pure alternation on ties.
module mux2t1_5_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = MUX_WIDTH,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt1,
  output logic             s,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             o_ready,
  output logic             last
);

  if (WIDTH != MUX_WIDTH) begin : gen_bad_width
    $error("mux2t1_5_arbiter: WIDTH must be 5");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : gen_bad_burst
    $error("mux2t1_5_arbiter: MAX_BURST must be in 1..15");
  end

  arb_state_e       state_q;
  logic [WIDTH-1:0] o_data_q;
  req_idx_t         last_q;
  req_idx_t         winner;
  logic             load_ok;
  logic             grant_any;
  logic [WIDTH-1:0] mux_o;

  // Full-and-draining still loads, so a steady stream has no bubbles.
  assign load_ok = (state_q == ST_EMPTY) || o_ready;

`ifdef ARB_LOCK_EN
  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  logic [3:0] burst_q;
  logic       owner_req;

  assign owner_req = last_q ? req1 : req0;
`endif

  always_comb begin
    winner = last_q;
    if (req0 && !req1) begin
      winner = 1'b0;
    end else if (req1 && !req0) begin
      winner = 1'b1;
    end else if (req0 && req1) begin
`ifdef ARB_LOCK_EN
      // A zero count means no active owner, so the tie alternates as usual.
      if (burst_q != 4'd0 && burst_q < MaxBurst) begin
        winner = last_q;
      end else begin
        winner = ~last_q;
      end
`else
      winner = ~last_q;
`endif
    end
  end

  // Grants are suppressed during reset even though load_ok is high there.
  assign gnt0      = rst_n && load_ok && req0 && (winner == 1'b0);
  assign gnt1      = rst_n && load_ok && req1 && (winner == 1'b1);
  assign grant_any = gnt0 || gnt1;

  MUX2T1_5 u_mux (
    .I0 (data0),
    .I1 (data1),
    .s  (winner),
    .o  (mux_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      o_data_q <= '0;
      last_q   <= 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (grant_any) state_q <= ST_FULL;
        ST_FULL:  if (o_ready && !grant_any) state_q <= ST_EMPTY;
      endcase
      if (grant_any) begin
        o_data_q <= mux_o;
        last_q   <= winner;
      end
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_q <= '0;
    end else if (load_ok) begin
      if (grant_any) begin
        if (winner == last_q && burst_q != 4'd0) begin
          if (burst_q != 4'd15) burst_q <= burst_q + 4'd1;
        end else begin
          burst_q <= 4'd1;
        end
      end else if (!owner_req) begin
        burst_q <= '0;
      end
    end
  end
`endif

  assign s       = winner;
  assign o_valid = (state_q == ST_FULL);
  assign o_data  = o_data_q;
  assign last    = last_q;

endmodule

// File: tb/tb_mux2t1_5_arbiter.sv
module tb_mux2t1_5_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic       o_ready = 1'b0;
  logic [4:0] data0 = '0;
  logic [4:0] data1 = '0;
  logic       gnt0, gnt1, s, o_valid, last;
  logic [4:0] o_data;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];

  // Reference model state (post-edge values, read at the falling edge)
  logic       m_valid, m_last, m_lok, m_win, m_g0, m_g1;
  logic [3:0] m_burst;
`ifdef ARB_LOCK_EN
  localparam logic [3:0] MaxBurst = 4'd4;
`endif

  always #5 clk = ~clk;

  mux2t1_5_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .data0   (data0),
    .gnt0    (gnt0),
    .req1    (req1),
    .data1   (data1),
    .gnt1    (gnt1),
    .s       (s),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_ready (o_ready),
    .last    (last)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected words pushed on predicted grants, compared while valid
  initial begin
    m_valid = 1'b0;
    m_last  = 1'b1;
    m_burst = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_valid = 1'b0;
        m_last  = 1'b1;
        m_burst = '0;
        exp_q.delete();
        check_val("rst_gnt", {gnt1, gnt0}, 0);
        check_val("rst_valid", o_valid, 0);
      end else begin
        m_lok = !m_valid || o_ready;
        m_win = m_last;
        if (req0 && !req1) m_win = 1'b0;
        else if (req1 && !req0) m_win = 1'b1;
        else if (req0 && req1) begin
`ifdef ARB_LOCK_EN
          m_win = (m_burst != 0 && m_burst < MaxBurst) ? m_last : !m_last;
`else
          m_win = !m_last;
`endif
        end
        m_g0 = m_lok && req0 && !m_win;
        m_g1 = m_lok && req1 && m_win;
        check_val("gnt0", gnt0, m_g0);
        check_val("gnt1", gnt1, m_g1);
        check_val("s", s, m_win);
        check_val("o_valid", o_valid, m_valid);
        check_val("last", last, m_last);
        if (m_valid) begin
          if (exp_q.size() == 0) check_val("sb_underflow", 1, 0);
          else begin
            check_val("o_data", o_data, exp_q[0]);
            if (o_ready) void'(exp_q.pop_front());
          end
        end
        if (m_g0) exp_q.push_back(data0);
        if (m_g1) exp_q.push_back(data1);
`ifdef ARB_LOCK_EN
        if (m_lok) begin
          if (m_g0 || m_g1) begin
            if (m_win == m_last && m_burst != 0) m_burst = (m_burst == 15) ? 4'd15 : m_burst + 1;
            else m_burst = 4'd1;
          end else if (!(m_last ? req1 : req0)) m_burst = '0;
        end
`endif
        if (m_g0 || m_g1) begin
          m_valid = 1'b1;
          m_last  = m_win;
        end else if (o_ready) m_valid = 1'b0;
      end
    end
  end

  logic [8:0] pat;
  int         npat;
  logic       g0s, g1s;

  initial begin
    // Reset with both requesting
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    repeat (3) step();
    check_val("reset_o_valid", o_valid, 0);
    check_val("reset_o_data", o_data, 0);
    check_val("reset_gnt", {gnt1, gnt0}, 0);
    check_val("reset_last", last, 1);
    req0 = 1'b0; req1 = 1'b0;
    #1 check_val("reset_idle_s", s, 1);
    step();
    rst_n = 1'b1;

    // Single requester
    req0 = 1'b1; data0 = 5'b01100; o_ready = 1'b1;
    #2 check_val("single_gnt0", gnt0, 1);
    check_val("single_s", s, 0);
    step();
    check_val("single_o_data", o_data, 5'b01100);
    check_val("single_o_valid", o_valid, 1);

    // Backpressure, then same-cycle grant on ready with no bubble
    data0 = 5'b00101;
    step();
    check_val("bp_load", o_data, 5'b00101);
    o_ready = 1'b0; data0 = 5'b10110;
    repeat (3) begin
      #2 check_val("bp_no_gnt", {gnt1, gnt0}, 0);
      step();
      check_val("bp_hold", o_data, 5'b00101);
      check_val("bp_valid", o_valid, 1);
    end
    o_ready = 1'b1;
    #2 check_val("bp_release_gnt", gnt0, 1);
    step();
    check_val("bp_nobubble_valid", o_valid, 1);
    check_val("bp_nobubble_data", o_data, 5'b10110);
    req0 = 1'b0; o_ready = 1'b0;
    step();

    // Reset while full: asynchronous drop, no grants during reset
    req0 = 1'b1; req1 = 1'b1; data0 = 5'b00000; data1 = 5'b00011;
    rst_n = 1'b0;
    #1 check_val("mid_rst_valid", o_valid, 0);
    check_val("mid_rst_gnt", {gnt1, gnt0}, 0);
    check_val("mid_rst_last", last, 1);
    step();
    step();
    rst_n = 1'b1; o_ready = 1'b1;

    // Tie pattern from a fresh reset
`ifdef ARB_LOCK_EN
    pat = 9'b0_1111_0000; npat = 9;
`else
    pat = 9'b0_0000_1010; npat = 4;
`endif
    for (int i = 0; i < npat; i++) begin
      #2 check_val("tie_gnt", {gnt1, gnt0}, pat[i] ? 2 : 1);
      step();
      check_val("tie_o_data", o_data, pat[i] ? 5'b00011 : 5'b00000);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();

    // Random traffic honouring hold-until-granted
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      g0s = gnt0; g1s = gnt1;
      step();
      if (g0s || !req0) begin req0 = ($urandom_range(0, 3) != 0); data0 = 5'($urandom); end
      if (g1s || !req1) begin req1 = ($urandom_range(0, 3) != 0); data1 = 5'($urandom); end
      o_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain
    @(negedge clk);
    g0s = gnt0; g1s = gnt1;
    step();
    req0 = 1'b0; req1 = 1'b0; o_ready = 1'b1;
    repeat (4) step();
    check_val("drain_valid", o_valid, 0);
    check_val("drain_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux2t1_5_arbiter.md
# mux2t1_5_arbiter

Round-robin arbiter that shares one 5-bit 2:1 multiplexer (`MUX2T1_5`) between two requesters and registers the selected word toward a single downstream consumer. It generates the mux select `s`, takes inputs with a valid/grant handshake, and emits outputs with a valid/ready handshake through a one-entry output register. It sits between two 5-bit producers and any single 5-bit sink in the experiment datapath.

## Interface
- `WIDTH`, 5: data width; must match the mux width, so only 5 is supported.
- `MAX_BURST`, 4: maximum consecutive grants to one owner when lock is compiled in; range 1..15.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req0` input 1: requester 0 has a valid word on `data0`.
- `data0` input 5: requester 0 word; drives mux `I0`.
- `gnt0` output 1: word on `data0` is accepted this cycle; combinational.
- `req1` input 1: requester 1 has a valid word on `data1`.
- `data1` input 5: requester 1 word; drives mux `I1`.
- `gnt1` output 1: word on `data1` is accepted this cycle; combinational.
- `s` output 1: mux select, 0 selects `data0` and 1 selects `data1`; combinational, equals the current winner.
- `o_valid` output 1: `o_data` holds a valid word.
- `o_data` output 5: registered word.
- `o_ready` input 1: sink accepts `o_data` this cycle.
- `last` output 1: registered index of the most recent granted requester.

## Operation
- Input transfer: requester k transfers on a rising edge when `reqk && gntk` are both high. A requester must hold `reqk` and `datak` stable until granted.
- Load enable: `load_ok = !o_valid || o_ready`. This gives pass-through when the register is full and being drained.
- Winner selection:
  - If only one request is high, that requester wins.
  - If both are high, the requester `!last` wins (round-robin).
  - If neither is high, `s` holds at `last` and both grants are 0.
- `gntk = load_ok && reqk && (winner == k)`. At most one grant is high in any cycle.
- FSM states:
  - EMPTY (`o_valid` = 0).
    - Any grant → FULL.
  - FULL (`o_valid` = 1).
    - `o_ready` high with a grant → FULL, loading a new word.
    - `o_ready` high with no grant → EMPTY.
    - `o_ready` low → FULL, `o_data` held.
- On a grant: `o_data` is loaded from the mux output, `o_valid` is set, and `last` is set to the winner.
- Simultaneous events: a drain and a load in the same cycle produce no bubble, so `o_valid` stays 1.
- Reset values:
  - `o_valid` = 0, `o_data` = 5'b00000.
  - `last` = 1, so requester 0 wins the first tie.
  - Burst counter = 0.
  - With no requests, `gnt0` = `gnt1` = 0 and `s` = 1.
- Reset mid-operation: the word held in the register is discarded. No grant is issued while `rst_n` is low.

## Timing
- Grant is same-cycle, combinational from `req*`, `o_valid`, `o_ready` and state.
- Latency is 1 cycle: a word granted at edge N appears on `o_data` with `o_valid` after edge N.
- Sustained throughput is one word per cycle while `o_ready` stays high.
- There are no combinational paths from `data*` to any output except through the mux into the register.

## Configuration
- `ARB_LOCK_EN` defined: burst lock.
  - If the owner `last` requests again while `load_ok`, it keeps the grant over a competing request, up to `MAX_BURST` consecutive grants.
  - A 4-bit burst counter increments on each repeat grant to the same owner.
  - The counter resets to 1 when ownership changes, and to 0 when the owner's request is low in a `load_ok` cycle.
  - When the count reaches `MAX_BURST`, the other requester wins the next tie.
- `ARB_LOCK_EN` undefined: pure alternation on every tie. No burst counter is instantiated.

## Structure
- A shared package `mux_arb_pkg` holds:
  - the `WIDTH` constant (5);
  - the state typedef {`ST_EMPTY`, `ST_FULL`};
  - the requester-index type (1 bit).
- One sub-module: the existing `MUX2T1_5`, instantiated as `u_mux`, with `I0` = `data0`, `I1` = `data1`, `s` = winner, and `o` feeding the output register.
- The winner logic, FSM and burst counter are written inline.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles with `req0` = `req1` = 1. Required: `o_valid` = 0, `o_data` = 0, no grants, `last` = 1.
- Single requester: `req0` = 1, `data0` = 5'b01100, `o_ready` = 1. Required: `gnt0` = 1 and `s` = 0 the same cycle; next cycle `o_data` = 5'b01100 and `o_valid` = 1.
- Tie alternation (`ARB_LOCK_EN` off): both requesting with `data0` = 5'b00000, `data1` = 5'b00011, `o_ready` = 1. Required grants 0,1,0,1 and `o_data` sequence 0,3,0,3.
- Backpressure: `o_ready` = 0 while full with 5'b00101. Required: no grants, `o_data` held at 5'b00101. Raising `o_ready` gives a same-cycle grant with no bubble.
- Burst lock (`ARB_LOCK_EN` on, `MAX_BURST` = 4): both requesting continuously. Required grant pattern 0,0,0,0,1,1,1,1,0.
- Reset mid-transfer: assert `rst_n` = 0 while FULL. Required: `o_valid` drops asynchronously, and after release the first tie goes to requester 0.
